// File: rtl/neda_pkg.sv
// Shared definitions for the NEDA bit-serial FIR: state encodings, width
// helpers and saturation limit macros.
`ifndef NEDA_PKG_SV
`define NEDA_PKG_SV

// Largest / smallest DW-bit signed value, expressed at AW bits (AW > DW).
`define NEDA_SAT_MAX(AW, DW) {{((AW)-(DW)+1){1'b0}}, {((DW)-1){1'b1}}}
`define NEDA_SAT_MIN(AW, DW) {{((AW)-(DW)+1){1'b1}}, {((DW)-1){1'b0}}}

package neda_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned acc_width(input int unsigned din_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return din_w + coef_w + clog2(taps);
  endfunction

endpackage

`endif

// File: rtl/neda_column_sum.sv
// Combinational column sum: adds the delay-line samples selected by one
// coefficient bit column through a balanced binary adder tree.
module neda_column_sum
  import neda_pkg::*;
#(
  parameter int unsigned TAPS  = 8,
  parameter int unsigned DIN_W = 8,
  parameter int unsigned ACC_W = 19
) (
  input  logic [TAPS*DIN_W-1:0]    i_x,
  input  logic [TAPS-1:0]          i_mask,
  output logic signed [ACC_W-1:0]  o_sum
);

  localparam int unsigned N = 1 << clog2(TAPS);

  // Heap layout: leaves at N..2N-1, node i = node 2i + node 2i+1, root at 1.
  logic signed [ACC_W-1:0] w_node [1:2*N-1];

  always_comb begin
    for (int unsigned i = 1; i < 2*N; i++) w_node[i] = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      if (i_mask[k]) w_node[N+k] = ACC_W'($signed(i_x[k*DIN_W +: DIN_W]));
    end
    for (int unsigned i = N-1; i >= 1; i--) begin
      w_node[i] = w_node[2*i] + w_node[2*i+1];
    end
  end

  assign o_sum = w_node[1];

endmodule

// File: rtl/neda_fir_param.sv
// Parametrised NEDA FIR: one coefficient bit column per cycle is summed and
// shift-accumulated, then saturated to DOUT_W behind valid/ready handshakes.
module neda_fir_param
  import neda_pkg::*;
#(
  parameter int unsigned TAPS   = 8,
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned DOUT_W = 16,
  parameter logic [TAPS*COEF_W-1:0] COEFS =
    {8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd4, 8'sd3, 8'sd2, 8'sd1}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DIN_W-1:0]  din,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned ACC_W = acc_width(DIN_W, COEF_W, TAPS);
  localparam int unsigned CNT_W = clog2(COEF_W);

  logic [1:0]                r_state;
  logic signed [DIN_W-1:0]   r_x [TAPS];
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_j;
  logic signed [DOUT_W-1:0]  r_dout;
  logic                      r_out_valid;

  logic [TAPS*DIN_W-1:0]     w_x_flat;
  logic [TAPS-1:0]           w_mask;
  logic signed [ACC_W-1:0]   w_col;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [DOUT_W-1:0]  w_sat;
  logic                      w_last;

  always_comb begin
    w_x_flat = '0;
    w_mask   = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      w_x_flat[k*DIN_W +: DIN_W] = r_x[k];
      w_mask[k] = COEFS[k*COEF_W + int'(r_j)];
    end
  end

  neda_column_sum #(
    .TAPS  (TAPS),
    .DIN_W (DIN_W),
    .ACC_W (ACC_W)
  ) u_column_sum (
    .i_x    (w_x_flat),
    .i_mask (w_mask),
    .o_sum  (w_col)
  );

  assign w_term = w_col <<< r_j;
  assign w_last = (r_j == CNT_W'(COEF_W - 1));

  generate
    if (ACC_W > DOUT_W) begin : g_clamp
      localparam logic signed [ACC_W-1:0] SAT_MAX = `NEDA_SAT_MAX(ACC_W, DOUT_W);
      localparam logic signed [ACC_W-1:0] SAT_MIN = `NEDA_SAT_MIN(ACC_W, DOUT_W);
      always_comb begin
        if (r_acc > SAT_MAX)      w_sat = SAT_MAX[DOUT_W-1:0];
        else if (r_acc < SAT_MIN) w_sat = SAT_MIN[DOUT_W-1:0];
        else                      w_sat = r_acc[DOUT_W-1:0];
      end
    end else begin : g_extend
      assign w_sat = DOUT_W'(r_acc);
    end
  endgenerate

  // DONE spends its first cycle registering the saturated result, which gives
  // the fixed COEF_W+1 latency from input handshake to out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      for (int unsigned k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc       <= '0;
      r_j         <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int unsigned k = TAPS-1; k >= 1; k--) r_x[k] <= r_x[k-1];
            r_x[0]  <= din;
            r_acc   <= '0;
            r_j     <= '0;
            r_state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          r_acc <= w_last ? (r_acc - w_term) : (r_acc + w_term);
          if (w_last) begin
            r_j     <= '0;
            r_state <= ST_DONE;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        ST_DONE: begin
          if (!r_out_valid) begin
            r_dout      <= w_sat;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign dout      = r_dout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_neda_fir_param.sv
// Self-checking bench for neda_fir_param: three coefficient sets checked
// against a direct convolution model with saturation.
module tb_neda_fir_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic signed [7:0]  din  [3];
  logic               iv   [3];
  logic               ir   [3];
  logic signed [15:0] dout [3];
  logic               ov   [3];
  logic               ordy [3];

  int checks = 0;
  int errors = 0;
  int coef [3][8];
  int hist [3][8];

  neda_fir_param u_def (
    .clk(clk), .rst(rst), .din(din[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .dout(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0])
  );

  neda_fir_param #(.COEFS({8{8'sd127}})) u_sat (
    .clk(clk), .rst(rst), .din(din[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .dout(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1])
  );

  neda_fir_param #(.COEFS({56'd0, 8'sh80})) u_sgn (
    .clk(clk), .rst(rst), .din(din[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .dout(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2])
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct convolution over the sample history, then clamp to 16 bits.
  function automatic int model(input int d);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(coef[d][k]) * longint'(hist[d][k]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++) hist[d][k] = 0;
  endtask

  task automatic push(input int d, input int v, input int hold, input bit poke);
    int n;
    logic signed [15:0] held;
    @(negedge clk);
    chk("in_ready_idle", ir[d], 1);
    din[d] = v[7:0];
    iv[d]  = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    for (int k = 7; k >= 1; k--) hist[d][k] = hist[d][k-1];
    hist[d][0] = v;
    chk("in_ready_busy", ir[d], 0);
    n = 0;
    while (ov[d] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    chk("dout", dout[d], model(d));
    held = dout[d];
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        @(negedge clk);
        iv[d]  = 1'b1;
        din[d] = 8'($urandom);
      end
      @(posedge clk); #1;
      chk("bp_valid", ov[d], 1);
      chk("bp_dout", dout[d], held);
      chk("bp_in_ready", ir[d], 0);
    end
    @(negedge clk);
    iv[d]   = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("valid_drop", ov[d], 0);
    chk("dout_hold", dout[d], held);
    chk("back_idle", ir[d], 1);
  endtask

  task automatic check_reset_state();
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", ov[d], 0);
      chk("rst_dout", dout[d], 0);
      chk("rst_in_ready", ir[d], 1);
    end
  endtask

  initial begin
    int def_c [8] = '{1, 2, 3, 4, 4, 3, 2, 1};
    for (int k = 0; k < 8; k++) begin
      coef[0][k] = def_c[k];
      coef[1][k] = 127;
      coef[2][k] = (k == 0) ? -128 : 0;
    end
    clear_model();
    for (int d = 0; d < 3; d++) begin
      din[d] = '0; iv[d] = 1'b0; ordy[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // Impulse
    push(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) push(0, 0, 0, 0);

    // Step up then down, first sample held under backpressure with stray input
    push(0, 10, 5, 1);
    for (int i = 0; i < 8; i++) push(0, 10, 0, 0);
    for (int i = 0; i < 12; i++) push(0, -2, 0, 0);
    chk("step_steady", dout[0], -40);

    // Saturation both ways
    for (int i = 0; i < 8; i++) push(1, 127, 0, 0);
    chk("sat_pos", dout[1], 32767);
    for (int i = 0; i < 8; i++) push(1, -128, 0, 0);
    chk("sat_neg", dout[1], -32768);

    // Sign-bit column
    push(2, -128, 0, 0);
    push(2, 127, 0, 0);

    // Reset while computing column j=3
    push(0, 5, 0, 0);
    @(negedge clk);
    din[0] = 8'sd7;
    iv[0]  = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check_reset_state();
    push(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) push(0, 0, 0, 0);

    // Random samples with random backpressure
    for (int i = 0; i < 40; i++)
      push(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    for (int i = 0; i < 30; i++)
      push(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 2)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
